// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue : RV32I decode-and-issue stage in front of the ALU.
//
// Takes one instruction per cycle together with its PC and register-file read
// data, decodes ALU control code, operand selection and immediate, and holds
// the result in a registered bundle offered to execute on a valid/ready
// handshake. Latency is one cycle; accept and issue can share an edge.
//
// Build option:
//   ALU_ISSUE_SKID_EN  defined   -> one extra skid entry; in_ready is a flop
//                                   output meaning "skid entry empty".
//                      undefined -> single entry; in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   in_inst, in_pc             instruction word and its PC
//   in_rs1, in_rs2             register read data
//   flush                      synchronous kill of every held entry
//   out_valid / out_ready      downstream handshake
//   out_a, out_b, out_ctr      ALU operands and control code
//   out_imm                    sign-extended immediate (branch/jump targets)
//   out_rd, out_wen            destination register and write enable
//   out_br, out_f3             conditional-branch flag and funct3
//   out_illegal                unrecognised opcode
// -----------------------------------------------------------------------------
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_ctr,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_br,
  output logic [2:0]      out_f3,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] CTR_ADD  = 4'b0000;
  localparam logic [3:0] CTR_SUB  = 4'b1000;
  localparam logic [3:0] CTR_SLL  = 4'b0001;
  localparam logic [3:0] CTR_SRL  = 4'b0101;
  localparam logic [3:0] CTR_SRA  = 4'b1101;
  localparam logic [3:0] CTR_SLTU = 4'b0010;
  localparam logic [3:0] CTR_SLT  = 4'b1010;
  localparam logic [3:0] CTR_PASS = 4'b0011;
  localparam logic [3:0] CTR_XOR  = 4'b0100;
  localparam logic [3:0] CTR_OR   = 4'b0110;
  localparam logic [3:0] CTR_AND  = 4'b0111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctr;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            wen;
    logic            br;
    logic [2:0]      f3;
    logic            illegal;
  } bundle_t;

  // ALU code for OP / OP-IMM. The alternate bit only turns add into sub for
  // the register form; for both forms it turns srl into sra.
  function automatic logic [3:0] arith_ctr(input logic [2:0] f3,
                                           input logic       alt,
                                           input logic       is_reg);
    logic [3:0] c;
    case (f3)
      3'b000:  c = (alt & is_reg) ? CTR_SUB : CTR_ADD;
      3'b001:  c = CTR_SLL;
      3'b010:  c = CTR_SLT;
      3'b011:  c = CTR_SLTU;
      3'b100:  c = CTR_XOR;
      3'b101:  c = alt ? CTR_SRA : CTR_SRL;
      3'b110:  c = CTR_OR;
      3'b111:  c = CTR_AND;
      default: c = CTR_ADD;
    endcase
    return c;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic            rd_nz;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  bundle_t         dec;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign rd     = in_inst[11:7];
  assign rd_nz  = (rd != 5'd0);
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'h000};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Instruction decode into an operand bundle.
  always_comb begin
    dec         = '0;
    dec.a       = in_rs1;
    dec.b       = in_rs2;
    dec.ctr     = CTR_ADD;
    dec.rd      = rd;
    dec.f3      = funct3;
    case (opcode)
      OPC_OP: begin
        dec.ctr = arith_ctr(funct3, in_inst[30], 1'b1);
        dec.wen = rd_nz;
      end
      OPC_OPIMM: begin
        dec.b   = imm_i;
        dec.imm = imm_i;
        dec.ctr = arith_ctr(funct3, in_inst[30], 1'b0);
        dec.wen = rd_nz;
      end
      OPC_LUI: begin
        dec.a   = '0;
        dec.b   = imm_u;
        dec.imm = imm_u;
        dec.ctr = CTR_PASS;
        dec.wen = rd_nz;
      end
      OPC_AUIPC: begin
        dec.a   = in_pc;
        dec.b   = imm_u;
        dec.imm = imm_u;
        dec.wen = rd_nz;
      end
      OPC_JAL: begin
        // ALU computes the link value pc + 4.
        dec.a   = in_pc;
        dec.b   = 32'd4;
        dec.imm = imm_j;
        dec.wen = rd_nz;
      end
      OPC_JALR: begin
        dec.a   = in_pc;
        dec.b   = 32'd4;
        dec.imm = imm_i;
        dec.wen = rd_nz;
      end
      OPC_LOAD: begin
        dec.b   = imm_i;
        dec.imm = imm_i;
        dec.wen = rd_nz;
      end
      OPC_STORE: begin
        dec.b   = imm_s;
        dec.imm = imm_s;
      end
      OPC_BRANCH: begin
        // Equality tests use sub (ALU Zero), ordered tests use the compares.
        dec.br  = 1'b1;
        dec.imm = imm_b;
        case (funct3[2:1])
          2'b10:   dec.ctr = CTR_SLT;
          2'b11:   dec.ctr = CTR_SLTU;
          default: dec.ctr = CTR_SUB;
        endcase
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  logic    accept;
  bundle_t out_q, out_d;
  logic    out_valid_q, out_valid_d;

  assign accept = in_valid & in_ready;

`ifdef ALU_ISSUE_SKID_EN
  bundle_t skid_q, skid_d;
  logic    skid_valid_q, skid_valid_d;

  assign in_ready = ~skid_valid_q;

  // Output/skid next state: a free output slot takes the skid entry first so
  // ordering is kept; a stalled output parks the new bundle in the skid.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (~out_valid_q | out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // Skid entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = ~out_valid_q | out_ready;

  // Single-entry next state: load on accept, empty on drain, hold on stall.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end
`endif

  // Output bundle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_ctr     = out_q.ctr;
  assign out_imm     = out_q.imm;
  assign out_rd      = out_q.rd;
  assign out_wen     = out_q.wen;
  assign out_br      = out_q.br;
  assign out_f3      = out_q.f3;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst, in_pc, in_rs1, in_rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b, out_imm;
  logic [3:0]  out_ctr;
  logic [4:0]  out_rd;
  logic        out_wen, out_br, out_illegal;
  logic [2:0]  out_f3;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_ctr(out_ctr), .out_imm(out_imm),
    .out_rd(out_rd), .out_wen(out_wen), .out_br(out_br), .out_f3(out_f3),
    .out_illegal(out_illegal)
  );

`ifdef ALU_ISSUE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct {
    logic [31:0] a, b, imm;
    logic [3:0]  ctr;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wen, br, ill;
    bit          ca, cb, ci;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   dut_issued = 0;
  bit   exp_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    logic [3:0] tab [8];
    logic [31:0] iimm, simm, bimm, uimm, jimm;
    int f3;
    bit writes;
    tab = '{4'b0000, 4'b0001, 4'b1010, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
    f3   = int'(inst[14:12]);
    iimm = 32'($signed(inst) >>> 20);
    simm = (iimm & ~32'h0000001F) | 32'(inst[11:7]);
    bimm = (inst[31] ? 32'hFFFFF000 : 32'h0) + (32'(inst[7]) << 11)
         + (32'(inst[30:25]) << 5) + (32'(inst[11:8]) << 1);
    uimm = inst & 32'hFFFFF000;
    jimm = (inst[31] ? 32'hFFF00000 : 32'h0) + (32'(inst[19:12]) << 12)
         + (32'(inst[20]) << 11) + (32'(inst[30:21]) << 1);
    e.rd = inst[11:7]; e.f3 = inst[14:12];
    e.a = rs1; e.b = rs2; e.imm = 32'h0; e.ctr = 4'b0000;
    e.br = 1'b0; e.ill = 1'b0; e.ca = 1'b1; e.cb = 1'b1; e.ci = 1'b1;
    writes = 1'b1;
    case (inst[6:0])
      7'b0110011: begin
        e.ctr = tab[f3];
        if (inst[30] && (f3 == 0)) e.ctr = 4'b1000;
        if (inst[30] && (f3 == 5)) e.ctr = 4'b1101;
        e.ci = 1'b0;
      end
      7'b0010011: begin
        e.b = iimm; e.imm = iimm; e.ctr = tab[f3];
        if (inst[30] && (f3 == 5)) e.ctr = 4'b1101;
      end
      7'b0110111: begin e.b = uimm; e.imm = uimm; e.ctr = 4'b0011; e.ca = 1'b0; end
      7'b0010111: begin e.a = pc; e.b = uimm; e.imm = uimm; end
      7'b1101111: begin e.a = pc; e.b = 32'd4; e.imm = jimm; end
      7'b1100111: begin e.a = pc; e.b = 32'd4; e.imm = iimm; end
      7'b0000011: begin e.b = iimm; e.imm = iimm; end
      7'b0100011: begin e.b = simm; e.imm = simm; writes = 1'b0; end
      7'b1100011: begin
        e.imm = bimm; e.br = 1'b1; writes = 1'b0;
        if (f3 < 2)      e.ctr = 4'b1000;
        else if (f3 < 6) e.ctr = 4'b1010;
        else             e.ctr = 4'b0010;
      end
      default: begin
        e.ill = 1'b1; writes = 1'b0; e.ca = 1'b0; e.cb = 1'b0; e.ci = 1'b0;
      end
    endcase
    e.wen = writes && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    logic [6:0]  opcs [10];
    logic [2:0]  bf3  [6];
    logic [6:0]  bad  [4];
    int sel;
    opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
             7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0000000};
    bf3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    bad  = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};
    w   = $urandom;
    sel = $urandom_range(0, 9);
    w[6:0] = opcs[sel];
    if (sel == 0) begin w[31] = 1'b0; w[29:25] = 5'd0; end
    if (sel == 8) w[14:12] = bf3[$urandom_range(0, 5)];
    if (sel == 9) w[6:0] = bad[$urandom_range(0, 3)];
    return w;
  endfunction

  task automatic check_outputs();
    exp_t e;
    exp_ready = SKID ? (q.size() < 2) : ((q.size() == 0) || out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      e = q[0];
      if (e.ca) chk("out_a", out_a, e.a);
      if (e.cb) chk("out_b", out_b, e.b);
      if (e.ci) chk("out_imm", out_imm, e.imm);
      chk("out_ctr", 32'(out_ctr), 32'(e.ctr));
      chk("out_rd", 32'(out_rd), 32'(e.rd));
      chk("out_f3", 32'(out_f3), 32'(e.f3));
      chk("out_wen", 32'(out_wen), 32'(e.wen));
      chk("out_br", 32'(out_br), 32'(e.br));
      chk("out_illegal", 32'(out_illegal), 32'(e.ill));
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  bit last_accept;
  task automatic cycle();
    bit do_acc, do_pop;
    exp_t e;
    @(negedge clk);
    check_outputs();
    do_acc = in_valid && exp_ready;
    do_pop = (q.size() > 0) && out_ready;
    if (out_valid && out_ready) dut_issued++;
    e = ref_decode(in_inst, in_pc, in_rs1, in_rs2);
    @(posedge clk);
    last_accept = do_acc;
    if (flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic issue1(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
    out_ready = 1'b1; in_valid = 1'b1; in_inst = inst; in_rs1 = rs1; in_rs2 = rs2;
    in_pc = 32'h0000_1000;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_ready"}, 32'(in_ready), 32'h1);
    chk({tag, "_a"}, out_a, 32'h0);
    chk({tag, "_b"}, out_b, 32'h0);
    chk({tag, "_imm"}, out_imm, 32'h0);
    chk({tag, "_ctl"}, {12'h0, out_ctr, out_rd, out_wen, out_br, out_f3, out_illegal},
        32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, guard, base;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 32'h0; in_rs1 = 32'h0; in_rs2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // add x3,x1,x2
    issue1(32'h002081B3, 32'd5, 32'd7);
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_ctr", 32'(out_ctr), 32'h0);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_wen", 32'(out_wen), 32'h1);
    issue1(32'h402081B3, 32'd9, 32'd4);
    chk("sub_ctr", 32'(out_ctr), 32'h8);
    issue1(32'h40315093, 32'h80000000, 32'd0);
    chk("srai_b", out_b, 32'h00000403);
    chk("srai_ctr", 32'(out_ctr), 32'hD);
    issue1(32'h123452B7, 32'd0, 32'd0);
    chk("lui_b", out_b, 32'h12345000);
    chk("lui_ctr", 32'(out_ctr), 32'h3);
    chk("lui_rd", 32'(out_rd), 32'd5);
    issue1(32'h0020C463, 32'd1, 32'd2);
    chk("blt_ctr", 32'(out_ctr), 32'hA);
    chk("blt_br", 32'(out_br), 32'h1);
    chk("blt_wen", 32'(out_wen), 32'h0);
    chk("blt_imm", out_imm, 32'd8);
    issue1(32'hFFFFFFFF, 32'd1, 32'd2);
    chk("ill_flag", 32'(out_illegal), 32'h1);
    chk("ill_wen", 32'(out_wen), 32'h0);
    cycle();

    // Backpressure: four adds, output stalled for the first three cycles.
    base = dut_issued; k = 0; guard = 0;
    while ((k < 4 || q.size() > 0) && guard < 40) begin
      out_ready = (guard >= 3);
      in_valid  = (k < 4);
      in_inst   = 32'h002081B3 | (32'(k + 1) << 7);
      in_rs1    = 32'(k * 10); in_rs2 = 32'(k + 100); in_pc = 32'(k * 4);
      #1;
      if (guard == 0) chk("bp_ready0", 32'(in_ready), 32'h1);
      if (guard == 1) chk("bp_ready1", 32'(in_ready), 32'(SKID));
      if (guard == 2) chk("bp_ready2", 32'(in_ready), 32'h0);
      cycle();
      if (last_accept) k++;
      guard++;
    end
    in_valid = 1'b0;
    chk("bp_issued", 32'(dut_issued - base), 32'd4);

    // Flush with an incoming bundle while one is held.
    issue1(32'h00a00093, 32'd0, 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; flush = 1'b1; in_inst = 32'h00b00113;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    base = dut_issued; out_ready = 1'b1;
    repeat (3) cycle();
    chk("flush_issued", 32'(dut_issued - base), 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 3);
      in_inst   = gen_inst();
      in_pc = $urandom; in_rs1 = $urandom; in_rs2 = $urandom;
      cycle();
    end
    flush = 1'b0;

    // Reset dropped mid-stream, away from any clock edge.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h002081B3;
    repeat (2) cycle();
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    in_valid = 1'b0; q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage that feeds the ALU. Accepts one RV32I instruction per cycle with its PC and register-file read data, and decodes the ALU control code, operand A/B selection and immediate. It presents a registered operand bundle to the execute stage over a valid/ready handshake, so it sits between instruction fetch / register read and the ALU.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream bundle valid.
- `in_ready`  out  1  stage can accept; a transfer occurs when `in_valid & in_ready` at a clock edge.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  32  instruction PC.
- `in_rs1`, `in_rs2`  in  32 each  register read data.
- `flush`  in  1  synchronous kill of all held entries.
- `out_valid`  out  1  issued bundle valid.
- `out_ready`  in  1  execute stage accepts.
- `out_a`, `out_b`  out  32 each  ALU operands.
- `out_ctr`  out  4  ALU control code.
- `out_imm`  out  32  sign-extended immediate, for branch/jump targets.
- `out_rd`  out  5  destination register.
- `out_wen`  out  1  register write enable; forced to 0 when rd = x0.
- `out_br`  out  1  conditional branch; the compare result is taken from the ALU `Less`/`Zero` outputs.
- `out_f3`  out  3  funct3, passed through.
- `out_illegal`  out  1  unrecognised opcode.

## Operation
- ALU control codes are fixed:
  - add 0000, sub 1000
  - sll 0001, srl 0101, sra 1101
  - unsigned less-than 0010, signed less-than 1010
  - pass B 0011
  - xor 0100, or 0110, and 0111
- OP (0110011):
  - A = rs1, B = rs2.
  - inst[30] selects sub over add, and sra over srl.
- OP-IMM (0010011):
  - A = rs1, B = I-immediate.
  - inst[30] selects sra over srl only; addi never becomes sub.
- LUI: B = U-immediate, ctr 0011.
- AUIPC: A = pc, B = U-immediate, add.
- JAL / JALR: A = pc, B = 4, add, so the ALU result is the link value.
- LOAD / STORE:
  - A = rs1, B = I- or S-immediate, add.
  - STORE sets `out_wen` = 0.
- BRANCH:
  - A = rs1, B = rs2, `out_wen` = 0, `out_br` = 1.
  - beq / bne use sub (the ALU raises `Zero` on equality).
  - blt / bge use 1010.
  - bltu / bgeu use 0010.
- Any other opcode:
  - `out_illegal` = 1, `out_wen` = 0, `out_br` = 0, ctr 0000.
  - The bundle still issues normally.
- Reset: all outputs 0; `in_ready` = 1.
- Flush:
  - Clears `out_valid`, and the skid entry if present, at the next edge.
  - An input transferred in the same cycle is discarded.
  - Flush takes priority over every other event.

## Timing
- Latency is 1 cycle: a bundle accepted at edge N is visible with `out_valid` = 1 after edge N.
- Throughput is 1 bundle per cycle while `out_ready` = 1.
- Output stability: while `out_valid & !out_ready`, every `out_*` signal holds stable.
- Accept and issue may occur in the same edge: the new bundle replaces the old one with no bubble.
- With no flush, no bundle is ever lost or duplicated.
- Reset asserted mid-transfer clears everything immediately, without waiting for a clock edge.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - Adds one skid entry; `in_ready` becomes a flop, equal to "skid empty".
  - If the output is stalled when an input arrives, the input goes to the skid entry.
  - When the output drains, the skid entry moves to the output on the same edge.
  - Ordering is preserved.
- `ALU_ISSUE_SKID_EN` undefined:
  - Single entry; `in_ready` = `!out_valid | out_ready`, which is combinational from `out_ready`.

## Test plan
- add x3,x1,x2: `in_inst` = 0x002081B3, rs1 = 5, rs2 = 7 -> next cycle `out_a` = 5, `out_b` = 7, `out_ctr` = 0000, `out_rd` = 3, `out_wen` = 1.
- Sub, srai and lui decode:
  - 0x402081B3 -> `out_ctr` = 1000.
  - srai 0x40315093 -> `out_b` = 0x00000403, `out_ctr` = 1101.
  - lui 0x123452B7 -> `out_b` = 0x12345000, `out_ctr` = 0011, `out_rd` = 5.
- blt x1,x2,+8: `in_inst` = 0x0020C463 -> `out_ctr` = 1010, `out_br` = 1, `out_wen` = 0, `out_imm` = 8.
- Backpressure: stream 4 adds while holding `out_ready` = 0 for 3 cycles -> outputs stay stable, all 4 issue in order, none lost or duplicated. Check `in_ready` per build:
  - with skid: `in_ready` drops only after 2 entries are held;
  - without skid: `in_ready` = 0 while stalled.
- Flush: assert `flush` together with `in_valid` while `out_valid` = 1 -> `out_valid` = 0 next cycle, and neither bundle ever issues.
- Illegal and reset:
  - `in_inst` = 0xFFFFFFFF -> `out_illegal` = 1, `out_wen` = 0.
  - Drop `rst_n` mid-stream -> all outputs 0 without waiting for a clock edge.
